// File: rtl/uart_tx_buffer.sv
// Byte FIFO plus dispatcher feeding a UART transmitter: pops one byte,
// pulses tx_start, then waits for tx_done_tick before launching the next.
module uart_tx_buffer #(
    parameter int DBIT   = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [DBIT-1:0]   wr_data,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   level,
    output logic              ovf,
    input  logic              ovf_clr,
    input  logic              tx_done_tick,
    output logic              tx_start,
    output logic [DBIT-1:0]   din,
    output logic              busy,
    output logic [1:0]        fsm_state
);

    // Handshakes: a host byte is taken on any cycle with wr_en=1 and full=0
    // (full acts as not-ready; a write while full is dropped and flags ovf).
    // Toward the transmitter, tx_start is a one-cycle valid with din stable,
    // and tx_done_tick is the transmitter's one-cycle completion/ready pulse.

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] FULL_LVL = {1'b1, {ADDR_W{1'b0}}};

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] LAUNCH = 2'd1;
    localparam logic [1:0] BUSY   = 2'd2;

    logic [DBIT-1:0]   mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [1:0]        state;
    logic              holdoff;
    logic              do_write;
    logic              pop;

    assign full      = (level == FULL_LVL);
    assign empty     = (level == '0);
    assign do_write  = wr_en && !full;
    // holdoff keeps one spare IDLE cycle after a completion so the
    // transmitter is back in its idle state before the next start.
    assign pop       = (state == IDLE) && !empty && !holdoff;
    assign tx_start  = (state == LAUNCH);
    assign busy      = (state != IDLE);
    assign fsm_state = state;

    always_ff @(posedge clk) begin
        if (do_write) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (do_write) wr_ptr <= wr_ptr + 1'b1;
            if (pop)      rd_ptr <= rd_ptr + 1'b1;
            if (do_write && !pop)      level <= level + 1'b1;
            else if (pop && !do_write) level <= level - 1'b1;
            if (wr_en && full) ovf <= 1'b1;
            else if (ovf_clr)  ovf <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            din     <= '0;
            holdoff <= 1'b0;
        end else begin
            holdoff <= 1'b0;
            case (state)
                IDLE: begin
                    if (pop) begin
                        din   <= mem[rd_ptr];
                        state <= LAUNCH;
                    end
                end
                LAUNCH: state <= BUSY;
                BUSY: begin
                    if (tx_done_tick) begin
                        state   <= IDLE;
                        holdoff <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
